vector_wb_sequencer: RTL and testbench
======================================

Name: vector_wb_sequencer

Overview:
Parametrised vector register write-back sequencer. It snapshots NUM_LANES lane results on a start pulse, then streams them one element per accepted beat to the vector register file write port. Streaming is bounded by the vector length, filtered by a per-element mask, and throttled by write-port backpressure. It sits between the vector ALU lanes and the vector register file, with a start/busy/done handshake toward the vector control FSM.

Parameters:
NUM_LANES, 8, number of lanes/elements per vector register (>=2)
DATA_W, 32, element width in bits
VLR_W, 32, width of the vector length input
REG_ADDR_W, 5, vector register address width
IDX_W, $clog2(NUM_LANES), element index width

Ports:
clk  in  1  clock; all state changes on its rising edge
pc_rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a write-back; honoured only in IDLE
vlr  in  VLR_W  vector length for this write-back, sampled on accepted start
vd_addr  in  REG_ADDR_W  destination vector register, sampled on accepted start
vmask  in  NUM_LANES  element enable mask, bit i = element i, sampled on accepted start
lane_data  in  NUM_LANES*DATA_W  flattened lane results; element i = bits [i*DATA_W +: DATA_W]
wr_ready  in  1  register file accepts the current beat
wr_valid  out  1  a write beat is presented
wr_addr  out  REG_ADDR_W  latched vd_addr
wr_elem  out  IDX_W  element index of the current beat
wr_data  out  DATA_W  snapshot data of the current element
busy  out  1  high in WRITE and DONE
done  out  1  one-cycle completion pulse
vlr_clamped  out  1  one-cycle pulse on the cycle after an accepted start with vlr > NUM_LANES

Behaviour:
- Reset (pc_rst=0, asynchronous): state=IDLE, idx=0, vlen=0, all snapshot regs=0. Outputs wr_valid, busy, done and vlr_clamped are 0; wr_addr, wr_elem and wr_data are 0. Reset mid-operation aborts immediately; no further beats are issued.
- States: IDLE, WRITE, DONE.
- IDLE plus start accepted:
  - Latch vd_addr, vmask and all lane_data into the snapshot.
  - vlen = min(vlr, NUM_LANES). Compare at full VLR_W width; no truncation before the compare. If vlr > NUM_LANES, pulse vlr_clamped next cycle.
  - If vlen==0, go to DONE with no beats. Otherwise go to WRITE with idx=0.
- WRITE:
  - wr_elem=idx.
  - wr_data = snapshot[idx], a mux from the registered snapshot, not from live lane_data.
  - wr_valid = vmask_latched[idx].
  - Advance when (wr_valid && wr_ready) or vmask_latched[idx]==0. Masked-off elements consume exactly one cycle with wr_valid=0 and ignore wr_ready.
  - If an advance happens at idx==vlen-1, go to DONE. Otherwise idx<=idx+1.
  - wr_valid held with wr_ready=0: idx, wr_data and wr_elem stay stable indefinitely.
- DONE: done=1 for exactly one cycle, wr_valid=0, then IDLE with idx=0.
- Start is ignored in WRITE and DONE. It is not queued. Sampled inputs are then don't-care. A start in the cycle DONE is high is also dropped.
- Live lane_data may change freely after the accepted start cycle.
- Latency: start at cycle T, first beat at T+1. With all mask bits set and wr_ready=1, beats occupy T+1..T+vlen and done is high at T+vlen+1.
- idx never exceeds vlen-1. No wrap beyond NUM_LANES-1.
- wr_addr holds the latched value from start until the next accepted start.

Decomposition:
- Shared package vpu_pkg: the state typedef (IDLE/WRITE/DONE), default NUM_LANES/DATA_W/REG_ADDR_W constants, and a clamp-length function.
- One natural sub-module, vector_wb_buffer: NUM_LANES x DATA_W snapshot register array with load enable, async active-low clear and indexed read mux.
- The FSM, index counter and handshake stay in vector_wb_sequencer.

Test Plan:
- Full vector: vlr=8, vmask=8'hFF, lane i = 32'h1000+i, wr_ready=1, start at T -> wr_valid T+1..T+8, wr_elem 0..7, wr_data 32'h1000..32'h1007; done only at T+9; busy T+1..T+9.
- Short/zero length: vlr=3 -> 3 beats (elements 0..2), done at T+4. vlr=0 -> no wr_valid, done at T+1, busy only at T+1.
- Mask and clamp: vlr=40, vmask=8'b1010_0101 -> vlr_clamped pulse at T+1; beats only for elements 0, 2, 5, 7; done at T+9.
- Backpressure plus snapshot: vlr=4, all enabled, wr_ready low for 3 cycles at element 1, lane_data changed after T -> element 1 held stable with old data; total 4 beats; done at T+8.
- Start while busy: second start with different vd_addr during WRITE, and another in the DONE cycle -> both ignored; wr_addr unchanged; exactly one done.
- Async reset: pc_rst=0 mid-stream at element 3 -> wr_valid, busy and done drop without a clock edge. After release, idle with wr_elem=0; a new start works normally.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared types and defaults for the vector write-back path.
package vpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } wb_state_t;

   localparam int DEF_NUM_LANES  = 8;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_VLR_W      = 32;
   localparam int DEF_REG_ADDR_W = 5;

   // Limit a requested vector length to the number of physical lanes.
   // Both operands are widened to 64 bits so the compare never truncates.
   function automatic logic [63:0] clamp_len(input logic [63:0] len,
                                             input logic [63:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/vector_wb_buffer.sv
// Snapshot of all lane results, captured on load and read by element index.
module vector_wb_buffer
   import vpu_pkg::*;
#(
   parameter int NUM_LANES = DEF_NUM_LANES,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int IDX_W     = $clog2(NUM_LANES)
) (
   input  logic                          clk,
   input  logic                          i_rst_n,
   input  logic                          i_load,
   input  logic [NUM_LANES*DATA_W-1:0]   i_lane_data,
   input  logic [IDX_W-1:0]              i_idx,
   output logic [DATA_W-1:0]             o_data
);

   logic [NUM_LANES-1:0][DATA_W-1:0] r_mem;

   // Capture every lane at once; afterwards live lane data is ignored.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem <= '0;
      end else if (i_load) begin
         r_mem <= i_lane_data;
      end
   end

   assign o_data = r_mem[i_idx];

endmodule

// File: rtl/vector_wb_sequencer.sv
// Streams a snapshotted vector, one element per accepted beat, to the
// vector register file write port, honouring length, mask and backpressure.
module vector_wb_sequencer
   import vpu_pkg::*;
#(
   parameter int NUM_LANES  = DEF_NUM_LANES,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int VLR_W      = DEF_VLR_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int IDX_W      = $clog2(NUM_LANES)
) (
   input  logic                          clk,
   input  logic                          pc_rst,
   input  logic                          start,
   input  logic [VLR_W-1:0]              vlr,
   input  logic [REG_ADDR_W-1:0]         vd_addr,
   input  logic [NUM_LANES-1:0]          vmask,
   input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
   input  logic                          wr_ready,
   output logic                          wr_valid,
   output logic [REG_ADDR_W-1:0]         wr_addr,
   output logic [IDX_W-1:0]              wr_elem,
   output logic [DATA_W-1:0]             wr_data,
   output logic                          busy,
   output logic                          done,
   output logic                          vlr_clamped
);

   // One extra bit so a length of exactly NUM_LANES is representable.
   localparam int LEN_W = IDX_W + 1;

   wb_state_t              r_state;
   wb_state_t              w_state_next;
   logic [IDX_W-1:0]       r_idx;
   logic [LEN_W-1:0]       r_vlen;
   logic [NUM_LANES-1:0]   r_vmask;
   logic [REG_ADDR_W-1:0]  r_addr;
   logic                   r_clamped;

   logic                   w_accept;
   logic                   w_vlr_gt;
   logic                   w_mask_bit;
   logic                   w_advance;
   logic                   w_last;
   logic [LEN_W-1:0]       w_vlen_new;

   assign w_accept   = (r_state == IDLE) && start;
   assign w_vlr_gt   = 64'(vlr) > 64'(NUM_LANES);
   assign w_vlen_new = LEN_W'(clamp_len(64'(vlr), 64'(NUM_LANES)));
   assign w_mask_bit = r_vmask[r_idx];
   assign w_last     = ({1'b0, r_idx} == (r_vlen - LEN_W'(1)));

   vector_wb_buffer #(
      .NUM_LANES (NUM_LANES),
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W)
   ) u_buffer (
      .clk         (clk),
      .i_rst_n     (pc_rst),
      .i_load      (w_accept),
      .i_lane_data (lane_data),
      .i_idx       (r_idx),
      .o_data      (wr_data)
   );

   // State register; reset aborts any write-back in progress.
   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state and handshake outputs; masked-off elements skip without waiting.
   always_comb begin
      w_state_next = r_state;
      w_advance    = 1'b0;
      wr_valid     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = (w_vlen_new == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            busy      = 1'b1;
            wr_valid  = w_mask_bit;
            w_advance = !w_mask_bit || wr_ready;
            if (w_advance && w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Latch the request on an accepted start and step the element index.
   always_ff @(posedge clk or negedge pc_rst) begin
      if (!pc_rst) begin
         r_idx     <= '0;
         r_vlen    <= '0;
         r_vmask   <= '0;
         r_addr    <= '0;
         r_clamped <= 1'b0;
      end else begin
         r_clamped <= 1'b0;
         if (w_accept) begin
            r_addr    <= vd_addr;
            r_vmask   <= vmask;
            r_vlen    <= w_vlen_new;
            r_idx     <= '0;
            r_clamped <= w_vlr_gt;
         end else if (w_advance) begin
            r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   assign wr_addr     = r_addr;
   assign wr_elem     = r_idx;
   assign vlr_clamped = r_clamped;

endmodule

// File: tb/tb_vector_wb_sequencer.sv
// Directed bench for vector_wb_sequencer with hand-computed expectations.
module tb_vector_wb_sequencer;

   localparam int NL = 8;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            pc_rst;
   logic            start;
   logic [31:0]     vlr;
   logic [4:0]      vd_addr;
   logic [NL-1:0]   vmask;
   logic [NL*DW-1:0] lane_data;
   logic            wr_ready;
   logic            wr_valid;
   logic [4:0]      wr_addr;
   logic [2:0]      wr_elem;
   logic [DW-1:0]   wr_data;
   logic            busy;
   logic            done;
   logic            vlr_clamped;

   int n_cmp = 0;
   int n_err = 0;

   vector_wb_sequencer dut (
      .clk         (clk),
      .pc_rst      (pc_rst),
      .start       (start),
      .vlr         (vlr),
      .vd_addr     (vd_addr),
      .vmask       (vmask),
      .lane_data   (lane_data),
      .wr_ready    (wr_ready),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_elem     (wr_elem),
      .wr_data     (wr_data),
      .busy        (busy),
      .done        (done),
      .vlr_clamped (vlr_clamped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_lanes(input logic [31:0] base);
      for (int i = 0; i < NL; i++) lane_data[i*DW +: DW] = base + 32'(i);
   endtask

   // Present a start for one cycle; returns in cycle T+1.
   task automatic do_start(input logic [31:0] len, input logic [4:0] addr,
                           input logic [7:0] mask);
      start   = 1'b1;
      vlr     = len;
      vd_addr = addr;
      vmask   = mask;
      tick();
      start   = 1'b0;
      vlr     = 32'hFFFF_FFFF;
      vd_addr = 5'd0;
      vmask   = 8'h00;
   endtask

   // Check the current WRITE cycle for one element.
   task automatic chk_beat(input string tag, input logic exp_valid,
                           input int elem, input logic [31:0] exp_data);
      chk({tag, "_valid"}, 64'(wr_valid), 64'(exp_valid));
      chk({tag, "_elem"},  64'(wr_elem),  64'(elem));
      if (exp_valid) chk({tag, "_data"}, 64'(wr_data), 64'(exp_data));
      chk({tag, "_busy"},  64'(busy),     64'd1);
      chk({tag, "_done"},  64'(done),     64'd0);
      $display("beat %s elem=%0d valid=%0b data=%h", tag, wr_elem, wr_valid, wr_data);
   endtask

   initial begin
      logic [7:0] m;

      pc_rst    = 1'b0;
      start     = 1'b0;
      vlr       = 32'd0;
      vd_addr   = 5'd0;
      vmask     = 8'h00;
      lane_data = '0;
      wr_ready  = 1'b1;
      #2;
      chk("rst_valid", 64'(wr_valid), 64'd0);
      chk("rst_busy",  64'(busy),     64'd0);
      chk("rst_done",  64'(done),     64'd0);
      chk("rst_clamp", 64'(vlr_clamped), 64'd0);
      chk("rst_addr",  64'(wr_addr),  64'd0);
      chk("rst_elem",  64'(wr_elem),  64'd0);
      chk("rst_data",  64'(wr_data),  64'd0);
      @(negedge clk);
      pc_rst = 1'b1;
      tick();

      // Full vector, exact length (no clamp).
      set_lanes(32'h1000);
      do_start(32'd8, 5'd5, 8'hFF);
      chk("full_clamp", 64'(vlr_clamped), 64'd0);
      for (int k = 0; k < 8; k++) begin
         chk_beat("full", 1'b1, k, 32'h1000 + 32'(k));
         chk("full_addr", 64'(wr_addr), 64'd5);
         tick();
      end
      chk("full_done",  64'(done),     64'd1);
      chk("full_dbusy", 64'(busy),     64'd1);
      chk("full_dvalid", 64'(wr_valid), 64'd0);
      tick();
      chk("full_idle_done", 64'(done), 64'd0);
      chk("full_idle_busy", 64'(busy), 64'd0);

      // Short length.
      set_lanes(32'h2000);
      do_start(32'd3, 5'd3, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         chk_beat("short", 1'b1, k, 32'h2000 + 32'(k));
         tick();
      end
      chk("short_done", 64'(done), 64'd1);
      tick();
      chk("short_idle", 64'(busy), 64'd0);

      // Zero length.
      do_start(32'd0, 5'd4, 8'hFF);
      chk("zero_valid", 64'(wr_valid), 64'd0);
      chk("zero_done",  64'(done),     64'd1);
      chk("zero_busy",  64'(busy),     64'd1);
      tick();
      chk("zero_done2", 64'(done), 64'd0);
      chk("zero_busy2", 64'(busy), 64'd0);
      $display("xfer zero-length complete");

      // Mask and clamp; wr_ready low on masked elements must not stall.
      set_lanes(32'hA000);
      m = 8'hA5;
      do_start(32'd40, 5'd6, m);
      chk("clamp_pulse", 64'(vlr_clamped), 64'd1);
      for (int k = 0; k < 8; k++) begin
         wr_ready = m[k];
         chk_beat("mask", m[k], k, 32'hA000 + 32'(k));
         tick();
         if (k == 0) chk("clamp_pulse_end", 64'(vlr_clamped), 64'd0);
      end
      wr_ready = 1'b1;
      chk("mask_done", 64'(done), 64'd1);
      tick();

      // Backpressure at element 1, live lane data changed after start.
      set_lanes(32'hB000);
      do_start(32'd4, 5'd8, 8'hFF);
      set_lanes(32'hDEAD_0000);
      chk_beat("bp0", 1'b1, 0, 32'hB000);
      tick();
      wr_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk_beat("bp_hold", 1'b1, 1, 32'hB001);
         tick();
      end
      wr_ready = 1'b1;
      chk_beat("bp1", 1'b1, 1, 32'hB001);
      tick();
      chk_beat("bp2", 1'b1, 2, 32'hB002);
      tick();
      chk_beat("bp3", 1'b1, 3, 32'hB003);
      tick();
      chk("bp_done", 64'(done), 64'd1);
      tick();

      // Starts during WRITE and DONE are dropped.
      set_lanes(32'hC000);
      do_start(32'd3, 5'd7, 8'h07);
      chk_beat("ign0", 1'b1, 0, 32'hC000);
      start = 1'b1; vd_addr = 5'd12; vlr = 32'd8; vmask = 8'hFF;
      tick();
      start = 1'b0;
      chk_beat("ign1", 1'b1, 1, 32'hC001);
      chk("ign_addr1", 64'(wr_addr), 64'd7);
      tick();
      chk_beat("ign2", 1'b1, 2, 32'hC002);
      tick();
      chk("ign_done", 64'(done), 64'd1);
      start = 1'b1; vd_addr = 5'd12; vlr = 32'd8; vmask = 8'hFF;
      tick();
      start = 1'b0;
      chk("ign_after_done", 64'(done),     64'd0);
      chk("ign_after_busy", 64'(busy),     64'd0);
      chk("ign_after_valid", 64'(wr_valid), 64'd0);
      chk("ign_addr2",      64'(wr_addr),  64'd7);
      tick();
      chk("ign_idle_busy",  64'(busy), 64'd0);
      chk("ign_idle_done",  64'(done), 64'd0);

      // Asynchronous reset mid-stream at element 3.
      set_lanes(32'h6000);
      do_start(32'd8, 5'd10, 8'hFF);
      for (int k = 0; k < 3; k++) tick();
      chk_beat("ar3", 1'b1, 3, 32'h6003);
      #2;
      pc_rst = 1'b0;
      #1;
      chk("ar_valid", 64'(wr_valid), 64'd0);
      chk("ar_busy",  64'(busy),     64'd0);
      chk("ar_done",  64'(done),     64'd0);
      chk("ar_elem",  64'(wr_elem),  64'd0);
      chk("ar_data",  64'(wr_data),  64'd0);
      @(negedge clk);
      pc_rst = 1'b1;
      tick();
      chk("ar_idle_busy", 64'(busy),    64'd0);
      chk("ar_idle_elem", 64'(wr_elem), 64'd0);
      chk("ar_idle_valid", 64'(wr_valid), 64'd0);
      set_lanes(32'h7000);
      do_start(32'd2, 5'd9, 8'h03);
      chk_beat("post0", 1'b1, 0, 32'h7000);
      chk("post_addr", 64'(wr_addr), 64'd9);
      tick();
      chk_beat("post1", 1'b1, 1, 32'h7001);
      tick();
      chk("post_done", 64'(done), 64'd1);
      tick();
      chk("post_idle", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
